// File: rtl/otter_io_pkg.sv
// Shared OTTER IO definitions: UART TX state encoding, register offsets, STATUS bit positions.
// UART_TX_PARITY_EN enables the PARITY state in otter_uart_tx.
package otter_io_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_tx_state_t;

  localparam int unsigned UART_TXDATA_OFS = 0;
  localparam int unsigned UART_STATUS_OFS = 4;
  localparam int unsigned UART_COUNT_OFS  = 8;

  localparam int unsigned UART_STAT_FULL  = 0;
  localparam int unsigned UART_STAT_EMPTY = 1;
  localparam int unsigned UART_STAT_BUSY  = 2;
  localparam int unsigned UART_STAT_OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: registered storage, wrapping pointers, count one bit wider than the pointers.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped UART transmitter on the OTTER IOBUS: TXDATA/STATUS/COUNT registers, FIFO, frame FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        IRQ_EMPTY
);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [2:0]     nxt_idx;
  logic [7:0]     shreg;
  logic           overflow;
  logic           sel_txdata, sel_status, sel_count;
  logic           push, ovf_clr, pop_c, baud_done;
  logic           full, empty;
  logic [7:0]     head;
  logic [CW-1:0]  count;
  logic           unused_bus;

  assign sel_txdata = (IOBUS_ADDR == BASE_ADDR + UART_TXDATA_OFS);
  assign sel_status = (IOBUS_ADDR == BASE_ADDR + UART_STATUS_OFS);
  assign sel_count  = (IOBUS_ADDR == BASE_ADDR + UART_COUNT_OFS);
  assign push       = IOBUS_WR && sel_txdata;
  assign ovf_clr    = IOBUS_WR && sel_status && IOBUS_OUT[3];
  assign unused_bus = ^IOBUS_OUT[31:8];

  assign baud_done = (baud_cnt == '0);
  assign nxt_idx   = bit_idx + 3'd1;
  // Head leaves the FIFO when a frame starts from IDLE or chains straight out of STOP
  assign pop_c     = !empty && ((state == UART_IDLE) || ((state == UART_STOP) && baud_done));
  assign IRQ_EMPTY = empty && (state == UART_IDLE);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .wdata   (IOBUS_OUT[7:0]),
    .pop     (pop_c),
    .rdata_c (head),
    .full_c  (full),
    .empty_c (empty),
    .count   (count)
  );

  always_comb begin
    IOBUS_IN = '0;
    if (sel_status) begin
      IOBUS_IN[UART_STAT_FULL]  = full;
      IOBUS_IN[UART_STAT_EMPTY] = empty;
      IOBUS_IN[UART_STAT_BUSY]  = (state != UART_IDLE);
      IOBUS_IN[UART_STAT_OVF]   = overflow;
    end else if (sel_count) begin
      IOBUS_IN = 32'(count);
    end
  end

  // Fullness is the pre-edge value, so a same-cycle pop cannot rescue a write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                overflow <= 1'b0;
    else if (push && full)  overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      TX       <= 1'b1;
    end else begin
      if (!baud_done) baud_cnt <= baud_cnt - BW'(1);
      case (state)
        UART_IDLE: begin
          TX <= 1'b1;
          if (!empty) begin
            state    <= UART_START;
            shreg    <= head;
            baud_cnt <= BIT_LOAD;
            TX       <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_done) begin
            state    <= UART_DATA;
            bit_idx  <= '0;
            baud_cnt <= BIT_LOAD;
            TX       <= shreg[0];
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_cnt <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= UART_PARITY;
              TX    <= ^shreg;
`else
              state <= UART_STOP;
              TX    <= 1'b1;
`endif
            end else begin
              bit_idx <= nxt_idx;
              TX      <= shreg[nxt_idx];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_PARITY: begin
          if (baud_done) begin
            state    <= UART_STOP;
            baud_cnt <= BIT_LOAD;
            TX       <= 1'b1;
          end
        end
`endif
        UART_STOP: begin
          if (baud_done) begin
            if (!empty) begin
              state    <= UART_START;
              shreg    <= head;
              baud_cnt <= BIT_LOAD;
              TX       <= 1'b0;
            end else begin
              state <= UART_IDLE;
              TX    <= 1'b1;
            end
          end
        end
        default: begin
          state <= UART_IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Scoreboard bench for otter_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
module tb_otter_uart_tx;
  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam int unsigned CPB  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME_T = NBITS * CPB * 10;

  logic        CLK, RST, IOBUS_WR, TX, IRQ_EMPTY;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     exp_q[$];
  longint start_q[$];
  bit     flush = 1'b0;
  longint t_wr, t_first, t_irq;
  int     n0;

  otter_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .TX         (TX),
    .IRQ_EMPTY  (IRQ_EMPTY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected line levels for one frame; parity is supplied by hand per byte
  task automatic expect_byte(input logic [7:0] b, input bit par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(par);
`else
    if (par) ;
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    t_wr = $time;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    check(name, IOBUS_IN, exp);
  endtask

  task automatic wait_irq(input int max_cyc, output longint t);
    t = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (IRQ_EMPTY) begin
        t = $time;
        break;
      end
    end
    n_checks++;
    if (t < 0) begin
      n_fail++;
      $display("FAIL irq_timeout: IRQ_EMPTY 0 after %0d cycles, required 1", max_cyc);
    end
  endtask

  task automatic check_start(input string name, input int idx, input longint ref_t, input longint delta);
    if (start_q.size() > idx) begin
      check(name, 32'(start_q[idx] - ref_t), 32'(delta));
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual no start bit #%0d, required one %0d after reference", name, idx, delta);
    end
  endtask

  // Monitor: detects start bits, samples mid-bit and pops the scoreboard
  initial begin : monitor
    bit aborted;
    bit exp_bit;
    forever begin
      @(negedge CLK);
      if (!RST && !flush && TX == 1'b0) begin
        start_q.push_back($time - 5);
        aborted = 1'b0;
        for (int b = 0; b < int'(NBITS); b++) begin
          repeat ((b == 0) ? 2 : 4) begin
            @(negedge CLK);
            if (flush || RST) aborted = 1'b1;
          end
          if (aborted) break;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_bit: actual bit %0d = %b of an unexpected frame, required idle", b, TX);
          end else begin
            exp_bit = exp_q.pop_front();
            check($sformatf("tx_bit%0d", b), 32'(TX), 32'(exp_bit));
          end
        end
      end
    end
  end

  initial begin
    RST        = 1'b1;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    repeat (2) @(negedge CLK);
    #1 check("tx_in_reset", 32'(TX), 32'h1);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset state and address decode
    check("tx_idle", 32'(TX), 32'h1);
    check("irq_idle", 32'(IRQ_EMPTY), 32'h1);
    rd_check("status_reset", BASE + 32'd4, 32'h2);
    rd_check("count_reset", BASE + 32'd8, 32'h0);
    rd_check("txdata_read", BASE, 32'h0);
    @(negedge CLK);
    rd_check("unmapped_read", BASE + 32'd12, 32'h0);
    bus_write(BASE + 32'd12, 32'h5A);
    bus_write(BASE - 32'd4, 32'h5A);
    repeat (2) @(negedge CLK);
    rd_check("count_unmapped_wr", BASE + 32'd8, 32'h0);
    check("frames_unmapped_wr", 32'(start_q.size()), 32'h0);

    // Single byte 0x55
    n0 = start_q.size();
    expect_byte(8'h55, 1'b0);
    bus_write(BASE, 32'h55);
    rd_check("status_after_push", BASE + 32'd4, 32'h0);
    rd_check("count_after_push", BASE + 32'd8, 32'h1);
    check("irq_low_after_push", 32'(IRQ_EMPTY), 32'h0);
    wait_irq(80, t_irq);
    check_start("start_0x55", n0, t_wr, 10);
    check("irq_return_0x55", 32'(t_irq - t_wr), 32'(10 + FRAME_T + 5));

    // Back-to-back 0xA1, 0xA2: contiguous frames
    @(negedge CLK);
    n0 = start_q.size();
    expect_byte(8'hA1, 1'b1);
    expect_byte(8'hA2, 1'b1);
    bus_write(BASE, 32'hA1);
    t_first = t_wr;
    bus_write(BASE, 32'hA2);
    wait_irq(140, t_irq);
    check("frames_a1a2", 32'(start_q.size() - n0), 32'h2);
    check_start("start_a1", n0, t_first, 10);
    check_start("start_a2", n0 + 1, t_first, 10 + FRAME_T);
    check("irq_return_a1a2", 32'(t_irq - t_first), 32'(10 + 2 * FRAME_T + 5));

    // Six-byte burst: first popped, four fill, sixth dropped
    @(negedge CLK);
    n0 = start_q.size();
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b0);
    expect_byte(8'h33, 1'b0);
    expect_byte(8'h44, 1'b0);
    expect_byte(8'h55, 1'b0);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    bus_write(BASE, 32'h44);
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h66);
    rd_check("status_overflow", BASE + 32'd4, 32'hD);
    rd_check("count_full", BASE + 32'd8, 32'h4);
    bus_write(BASE + 32'd4, 32'h8);
    rd_check("status_ovf_cleared", BASE + 32'd4, 32'h5);
    wait_irq(5 * NBITS * CPB + 40, t_irq);
    check("frames_burst", 32'(start_q.size() - n0), 32'h5);
    rd_check("status_burst_done", BASE + 32'd4, 32'h2);

    // Reset mid-DATA of 0xFF with a second byte queued
    @(negedge CLK);
    expect_byte(8'hFF, 1'b0);
    bus_write(BASE, 32'hFF);
    bus_write(BASE, 32'h0F);
    rd_check("count_before_rst", BASE + 32'd8, 32'h1);
    repeat (7) @(negedge CLK);
    #2;
    flush = 1'b1;
    RST   = 1'b1;
    #1;
    check("tx_async_rst", 32'(TX), 32'h1);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    rd_check("count_after_rst", BASE + 32'd8, 32'h0);
    rd_check("status_after_rst", BASE + 32'd4, 32'h2);
    n0 = start_q.size();
    flush = 1'b0;
    repeat (60) @(negedge CLK);
    check("frames_after_rst", 32'(start_q.size() - n0), 32'h0);
    check("tx_after_rst", 32'(TX), 32'h1);

    // Parity vectors: 0x07 has odd weight, 0x03 even
    n0 = start_q.size();
    expect_byte(8'h07, 1'b1);
    bus_write(BASE, 32'h07);
    wait_irq(80, t_irq);
    check_start("start_0x07", n0, t_wr, 10);
    check("frame_len_0x07", 32'(t_irq - t_wr), 32'(10 + FRAME_T + 5));
    @(negedge CLK);
    expect_byte(8'h03, 1'b0);
    bus_write(BASE, 32'h03);
    wait_irq(80, t_irq);
    check("frame_len_0x03", 32'(t_irq - t_wr), 32'(10 + FRAME_T + 5));

    repeat (4) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
